// File: rtl/pla_dut_top.sv
// XGMII monitor/forwarder: per-port frame FSM, forward/blank, stats, 16-bit localbus.
// Latency: 1 cycle data path, 1 cycle read. No backpressure. Optional: PLA_CNT_SAT_EN (saturating counters).
module pla_dut_top #(
   parameter int NPORT   = 4,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1522
) (
   input  logic        I_312m5_clk,
   input  logic        I_rst,
   input  logic [31:0] I_xgmii_txd,
   input  logic [3:0]  I_xgmii_txc,
   input  logic [1:0]  I_xgmii_port,
   input  logic        I_lb_cs_n,
   input  logic        I_lb_wr_n,
   input  logic        I_lb_rd_n,
   input  logic [15:0] I_lb_addr,
   input  logic [15:0] I_lb_din,
   output logic [15:0] O_lb_dout,
   output logic [31:0] O_xgmii_txd,
   output logic [3:0]  O_xgmii_txc,
   output logic [1:0]  O_xgmii_port
);

   localparam logic [31:0] IDLE_WORD = 32'h0707_0707;

   typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA} st_t;

   st_t             st        [NPORT];
   logic [15:0]     byte_cnt  [NPORT];
   logic [15:0]     tpid      [NPORT];
   logic [NPORT-1:0] fwd_q;

   logic [15:0] good_cnt [NPORT];
   logic [15:0] err_cnt  [NPORT];
   logic [15:0] tag_cnt  [NPORT];
   logic [15:0] last_len [NPORT];

   logic        wr_n_q;
   logic        cnt_clr_q;
   logic        glb_en;
   logic [15:0] port_en;
   logic [3:0]  fwd_en;
   logic [2:0]  tag_en;

   logic        lb_wr;
   logic [15:0] rdata;

   st_t         cur_st, nxt_st;
   logic [15:0] cur_bytes, nxt_bytes, end_len;
   logic        is_sof, is_sfd, is_term;
   logic [1:0]  hi_lane;
   logic [7:0]  term_byte;
   logic [16:0] sum4, sum_tail;
   logic        sof, cap_tpid, pre_err, frame_end, frame_err, tag_hit;
   logic        new_fwd, word_fwd, cnt_ok;

   function automatic logic [15:0] cnt_inc(input logic [15:0] v);
`ifdef PLA_CNT_SAT_EN
      return (v == 16'hFFFF) ? v : v + 16'd1;
`else
      return v + 16'd1;
`endif
   endfunction

   assign lb_wr = !I_lb_cs_n && !I_lb_wr_n && wr_n_q;

   // Localbus register file and read port
   always_ff @(posedge I_312m5_clk) begin
      if (I_rst) begin
         wr_n_q    <= 1'b0;
         cnt_clr_q <= 1'b0;
         glb_en    <= 1'b0;
         port_en   <= '0;
         fwd_en    <= '0;
         tag_en    <= '0;
         O_lb_dout <= '0;
      end else begin
         wr_n_q    <= I_lb_wr_n;
         cnt_clr_q <= lb_wr && (I_lb_addr == 16'h0310) && I_lb_din[0];
         if (lb_wr) begin
            case (I_lb_addr)
               16'h0310: glb_en  <= I_lb_din[1];
               16'h0313: port_en <= I_lb_din & 16'h0F0F;
               16'h0314: fwd_en  <= I_lb_din[3:0];
               16'h031E: tag_en  <= I_lb_din[2:0];
               default: ;
            endcase
         end
         if (!I_lb_cs_n && !I_lb_rd_n)
            O_lb_dout <= rdata;
      end
   end

   always_comb begin
      rdata = '0;
      case (I_lb_addr)
         16'h0310: rdata = {14'd0, glb_en, 1'b0};
         16'h0313: rdata = port_en;
         16'h0314: rdata = {12'd0, fwd_en};
         16'h031E: rdata = {13'd0, tag_en};
         default: begin
            if (I_lb_addr[15:4] == 12'h032) begin
               case (I_lb_addr[1:0])
                  2'd0: rdata = good_cnt[I_lb_addr[3:2]];
                  2'd1: rdata = err_cnt[I_lb_addr[3:2]];
                  2'd2: rdata = tag_cnt[I_lb_addr[3:2]];
                  default: rdata = last_len[I_lb_addr[3:2]];
               endcase
            end
         end
      endcase
   end

   // Word decode; the highest flagged lane is where a terminate must sit
   always_comb begin
      hi_lane = 2'd0;
      for (int i = 0; i < 4; i++)
         if (I_xgmii_txc[i]) hi_lane = 2'(i);
   end

   assign term_byte = I_xgmii_txd[{hi_lane, 3'b000} +: 8];
   assign is_sof    = (I_xgmii_txc == 4'h8) && (I_xgmii_txd == 32'hFB55_5555);
   assign is_sfd    = (I_xgmii_txc == 4'h0) && (I_xgmii_txd == 32'h5555_55D5);
   assign is_term   = (I_xgmii_txc != 4'h0) && (term_byte == 8'hFD);
   assign cur_st    = st[I_xgmii_port];
   assign cur_bytes = byte_cnt[I_xgmii_port];
   assign sum4      = {1'b0, cur_bytes} + 17'd4;
   assign sum_tail  = {1'b0, cur_bytes} + {15'd0, 2'd3 - hi_lane};

   always_comb begin
      nxt_st    = cur_st;
      nxt_bytes = cur_bytes;
      end_len   = cur_bytes;
      sof       = 1'b0;
      cap_tpid  = 1'b0;
      pre_err   = 1'b0;
      frame_end = 1'b0;
      frame_err = 1'b0;
      case (cur_st)
         ST_IDLE: begin
            if (is_sof) begin
               nxt_st    = ST_PRE;
               nxt_bytes = '0;
               sof       = 1'b1;
            end
         end
         ST_PRE: begin
            if (is_sfd) begin
               nxt_st = ST_DATA;
            end else begin
               nxt_st  = ST_IDLE;
               pre_err = 1'b1;
            end
         end
         ST_DATA: begin
            if (I_xgmii_txc == 4'h0) begin
               nxt_bytes = sum4[16] ? 16'hFFFF : sum4[15:0];
               cap_tpid  = (cur_bytes == 16'd12);
            end else if (is_term) begin
               end_len   = sum_tail[16] ? 16'hFFFF : sum_tail[15:0];
               frame_end = 1'b1;
               frame_err = (end_len < 16'(MIN_LEN)) || (end_len > 16'(MAX_LEN));
               nxt_st    = ST_IDLE;
            end else begin
               // Stray control or a new start aborts the frame; a start re-arms the FSM
               frame_end = 1'b1;
               frame_err = 1'b1;
               nxt_st    = is_sof ? ST_PRE : ST_IDLE;
               nxt_bytes = is_sof ? 16'd0 : cur_bytes;
               sof       = is_sof;
            end
         end
         default: nxt_st = ST_IDLE;
      endcase
   end

   assign tag_hit = (end_len >= 16'd14) &&
                    ((tag_en[0] && tpid[I_xgmii_port] == 16'h8100) ||
                     (tag_en[1] && tpid[I_xgmii_port] == 16'h88A8) ||
                     (tag_en[2] && tpid[I_xgmii_port] == 16'h9100));
   assign new_fwd  = glb_en && port_en[I_xgmii_port] && fwd_en[I_xgmii_port];
   assign word_fwd = sof ? new_fwd : ((cur_st == ST_IDLE) ? glb_en : fwd_q[I_xgmii_port]);
   assign cnt_ok   = glb_en && port_en[I_xgmii_port] && port_en[{2'b10, I_xgmii_port}];

   always_ff @(posedge I_312m5_clk) begin
      if (I_rst) begin
         for (int i = 0; i < NPORT; i++) begin
            st[i]       <= ST_IDLE;
            byte_cnt[i] <= '0;
            tpid[i]     <= '0;
         end
         fwd_q <= '0;
      end else begin
         st[I_xgmii_port]       <= nxt_st;
         byte_cnt[I_xgmii_port] <= nxt_bytes;
         if (sof) begin
            tpid[I_xgmii_port]  <= '0;
            fwd_q[I_xgmii_port] <= new_fwd;
         end else if (cap_tpid) begin
            tpid[I_xgmii_port] <= I_xgmii_txd[31:16];
         end
      end
   end

   always_ff @(posedge I_312m5_clk) begin
      if (I_rst || cnt_clr_q) begin
         for (int i = 0; i < NPORT; i++) begin
            good_cnt[i] <= '0;
            err_cnt[i]  <= '0;
            tag_cnt[i]  <= '0;
            last_len[i] <= '0;
         end
      end else if (cnt_ok) begin
         if (pre_err || (frame_end && frame_err))
            err_cnt[I_xgmii_port] <= cnt_inc(err_cnt[I_xgmii_port]);
         if (frame_end && !frame_err)
            good_cnt[I_xgmii_port] <= cnt_inc(good_cnt[I_xgmii_port]);
         if (frame_end)
            last_len[I_xgmii_port] <= end_len;
         if (frame_end && tag_hit)
            tag_cnt[I_xgmii_port] <= cnt_inc(tag_cnt[I_xgmii_port]);
      end
   end

   always_ff @(posedge I_312m5_clk) begin
      if (I_rst) begin
         O_xgmii_txd  <= IDLE_WORD;
         O_xgmii_txc  <= 4'hF;
         O_xgmii_port <= 2'd0;
      end else begin
         O_xgmii_txd  <= word_fwd ? I_xgmii_txd : IDLE_WORD;
         O_xgmii_txc  <= word_fwd ? I_xgmii_txc : 4'hF;
         O_xgmii_port <= I_xgmii_port;
      end
   end

endmodule

// File: tb/tb_pla_dut_top.sv
// Self-checking bench for pla_dut_top: scoreboarded XGMII output plus localbus register/stat reads.
`timescale 1ns/1ps
module tb_pla_dut_top;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_txd;
   logic [3:0]  i_txc;
   logic [1:0]  i_port;
   logic        cs_n, wr_n, rd_n;
   logic [15:0] addr, din;
   logic [15:0] lb_dout;
   logic [31:0] o_txd;
   logic [3:0]  o_txc;
   logic [1:0]  o_port;

   int checks   = 0;
   int failures = 0;

   logic [31:0] fr_d[$];
   logic [3:0]  fr_c[$];
   logic [37:0] exp_q[$];
   logic [37:0] mon_e;

   localparam logic [31:0] IDLE = 32'h0707_0707;

   pla_dut_top dut (
      .I_312m5_clk (clk),
      .I_rst       (rst),
      .I_xgmii_txd (i_txd),
      .I_xgmii_txc (i_txc),
      .I_xgmii_port(i_port),
      .I_lb_cs_n   (cs_n),
      .I_lb_wr_n   (wr_n),
      .I_lb_rd_n   (rd_n),
      .I_lb_addr   (addr),
      .I_lb_din    (din),
      .O_lb_dout   (lb_dout),
      .O_xgmii_txd (o_txd),
      .O_xgmii_txc (o_txc),
      .O_xgmii_port(o_port)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: one expected output word per clocked input word
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if ({o_port, o_txc, o_txd} !== mon_e) begin
            failures++;
            $display("FAIL xgmii_out got port=%0d txc=%h txd=%h exp port=%0d txc=%h txd=%h",
                     o_port, o_txc, o_txd, mon_e[37:36], mon_e[35:32], mon_e[31:0]);
         end
      end
   end

   task automatic build_frame(input int ndata, input logic [15:0] tp,
                              input logic [31:0] last_d, input logic [3:0] last_c);
      logic [31:0] w;
      fr_d.delete(); fr_c.delete();
      fr_d.push_back(32'hFB55_5555); fr_c.push_back(4'h8);
      fr_d.push_back(32'h5555_55D5); fr_c.push_back(4'h0);
      for (int i = 0; i < ndata; i++) begin
         w = {8'hA5, 8'(i), 8'h3C, 8'(i + 7)};
         if (i == 3) w[31:16] = tp;
         fr_d.push_back(w); fr_c.push_back(4'h0);
      end
      fr_d.push_back(last_d); fr_c.push_back(last_c);
   endtask

   task automatic send_words(input logic [1:0] p, input bit fwd);
      for (int i = 0; i < fr_d.size(); i++) begin
         i_txd = fr_d[i]; i_txc = fr_c[i]; i_port = p;
         @(posedge clk);
         exp_q.push_back(fwd ? {p, fr_c[i], fr_d[i]} : {p, 4'hF, IDLE});
         #1;
      end
      i_txd = IDLE; i_txc = 4'hF;
   endtask

   task automatic lb_write(input logic [15:0] a, input logic [15:0] d);
      addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
      @(posedge clk); #1;
      cs_n = 1'b1; wr_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic lb_read(input logic [15:0] a, output logic [15:0] v);
      addr = a; cs_n = 1'b0; rd_n = 1'b0;
      @(posedge clk); #1;
      v = lb_dout;
      cs_n = 1'b1; rd_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [15:0] v;
      rst = 1'b1; i_txd = 32'h1234_5678; i_txc = 4'h0; i_port = 2'd3;
      cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; addr = '0; din = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (o_txd !== IDLE || o_txc !== 4'hF || o_port !== 2'd0 || lb_dout !== 16'd0) begin
         failures++;
         $display("FAIL reset_outputs got txd=%h txc=%h port=%0d dout=%h", o_txd, o_txc, o_port, lb_dout);
      end
      rst = 1'b0; i_txd = IDLE; i_txc = 4'hF; i_port = 2'd0;
      @(posedge clk); #1;
      lb_read(16'h0313, v);
      checks++;
      if (v !== 16'h0000) begin failures++; $display("FAIL reset_port_en got %h exp 0000", v); end
      lb_read(16'h0320, v);
      checks++;
      if (v !== 16'h0000) begin failures++; $display("FAIL reset_good_cnt got %h exp 0000", v); end
   endtask

   task automatic test_regs();
      logic [15:0] a[5]  = '{16'h0310, 16'h0313, 16'h0314, 16'h031E, 16'h0300};
      logic [15:0] ex[5] = '{16'h0002, 16'h0F0F, 16'h000F, 16'h0007, 16'h0000};
      logic [15:0] v;
      lb_write(16'h0310, 16'h0002);
      lb_write(16'h0313, 16'h0F0F);
      lb_write(16'h0314, 16'h000F);
      lb_write(16'h031E, 16'h0007);
      for (int i = 0; i < 5; i++) begin
         lb_read(a[i], v);
         checks++;
         if (v !== ex[i]) begin failures++; $display("FAIL reg_readback addr=%h got %h exp %h", a[i], v, ex[i]); end
      end
   endtask

   task automatic check_stats(input string nm, input logic [15:0] base,
                              input logic [15:0] g, input logic [15:0] e,
                              input logic [15:0] t, input logic [15:0] l);
      logic [15:0] ex[4];
      logic [15:0] v;
      ex = '{g, e, t, l};
      for (int i = 0; i < 4; i++) begin
         lb_read(base + 16'(i), v);
         checks++;
         if (v !== ex[i]) begin failures++; $display("FAIL %s addr=%h got %0d exp %0d", nm, base + 16'(i), v, ex[i]); end
      end
   endtask

   task automatic test_forward();
      build_frame(26, 16'h8100, 32'h086E_4BFD, 4'h1);
      send_words(2'd0, 1'b1);
      check_stats("fwd_stats", 16'h0320, 16'd1, 16'd0, 16'd1, 16'd107);
   endtask

   task automatic test_blank();
      lb_write(16'h0314, 16'h0000);
      build_frame(26, 16'h8100, 32'h086E_4BFD, 4'h1);
      send_words(2'd0, 1'b0);
      check_stats("blank_stats", 16'h0320, 16'd2, 16'd0, 16'd2, 16'd107);
      lb_write(16'h0314, 16'h000F);
   endtask

   task automatic test_trunc();
      build_frame(10, 16'h0800, 32'hFD07_0707, 4'h8);
      send_words(2'd1, 1'b1);
      check_stats("trunc_stats", 16'h0324, 16'd0, 16'd1, 16'd0, 16'd40);
   endtask

   task automatic test_pre_err();
      fr_d = '{32'hFB55_5555, 32'h1234_5678};
      fr_c = '{4'h8, 4'h0};
      send_words(2'd2, 1'b1);
      check_stats("pre_err_stats", 16'h0328, 16'd0, 16'd1, 16'd0, 16'd0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] ad[$], bd[$];
      logic [3:0]  ac[$], bc[$];
      int n;
      build_frame(26, 16'h8100, 32'h086E_4BFD, 4'h1);
      ad = fr_d; ac = fr_c;
      build_frame(16, 16'h9100, 32'hFD07_0707, 4'h8);
      bd = fr_d; bc = fr_c;
      n = (ad.size() > bd.size()) ? ad.size() : bd.size();
      for (int i = 0; i < n; i++) begin
         if (i < ad.size()) begin
            i_txd = ad[i]; i_txc = ac[i]; i_port = 2'd0;
            @(posedge clk); exp_q.push_back({2'd0, ac[i], ad[i]}); #1;
         end
         if (i < bd.size()) begin
            i_txd = bd[i]; i_txc = bc[i]; i_port = 2'd3;
            @(posedge clk); exp_q.push_back({2'd3, bc[i], bd[i]}); #1;
         end
      end
      i_txd = IDLE; i_txc = 4'hF; i_port = 2'd0;
      check_stats("b2b_port0", 16'h0320, 16'd3, 16'd0, 16'd3, 16'd107);
      check_stats("b2b_port3", 16'h032C, 16'd1, 16'd0, 16'd1, 16'd64);
   endtask

   task automatic test_clear();
      logic [15:0] v;
      build_frame(26, 16'h8100, 32'h086E_4BFD, 4'h1);
      send_words(2'd0, 1'b1);
      send_words(2'd0, 1'b1);
      lb_read(16'h0320, v);
      checks++;
      if (v !== 16'd5) begin failures++; $display("FAIL clear_pre_good got %0d exp 5", v); end
      lb_write(16'h0310, 16'h0003);
      check_stats("clear_port0", 16'h0320, 16'd0, 16'd0, 16'd0, 16'd0);
      check_stats("clear_port1", 16'h0324, 16'd0, 16'd0, 16'd0, 16'd0);
      lb_read(16'h0310, v);
      checks++;
      if (v !== 16'h0002) begin failures++; $display("FAIL clear_ctrl got %h exp 0002", v); end
   endtask

   task automatic test_glb_off();
      lb_write(16'h0310, 16'h0000);
      build_frame(26, 16'h8100, 32'h086E_4BFD, 4'h1);
      send_words(2'd0, 1'b0);
      check_stats("glb_off_stats", 16'h0320, 16'd0, 16'd0, 16'd0, 16'd0);
   endtask

   initial begin
      test_reset();
      test_regs();
      test_forward();
      test_blank();
      test_trunc();
      test_pre_err();
      test_back_to_back();
      test_clear();
      test_glb_off();
      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
